// File: rtl/i2c_pkg.sv
// Shared state encoding and line constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic SDA_RELEASE = 1'b1;
    localparam logic SDA_LOW     = 1'b0;

    localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA with edge, START and STOP pulse detection.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    // Idle bus is high, so the chain resets high to avoid a false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    always_comb begin
        sda_sync  = sda_sync_q;
        scl_rise  = scl_sync_q & ~scl_prev_q;
        scl_fall  = ~scl_sync_q & scl_prev_q;
        start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
        stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, byte register pointer with auto-increment and a
// simple register-bus master toward local logic.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR    = 7'h50,
    parameter int unsigned REG_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ext_scl_i,
    input  logic                      ext_sda_i,
    output logic                      ext_sda_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]                reg_wdata,
    output logic                      reg_we,
    output logic                      reg_re,
    input  logic [7:0]                reg_rdata,
    output logic                      busy
);

    logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (ext_scl_i),
        .sda_i     (ext_sda_i),
        .sda_sync  (sda_sync),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]                rx_q, rx_d, tx_q, tx_d;
    logic                      rw_q, rw_d;
    logic                      sda_o_q, sda_o_d;
    logic                      busy_q, busy_d;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]                reg_wdata_q, reg_wdata_d;
    logic                      reg_we_q, reg_we_d;
    logic                      reg_re_q, reg_re_d;
    logic                      load_q, load_d;
    logic [7:0]                rx_byte;
    logic                      last_bit;

    always_comb begin
        rx_byte     = {rx_q[6:0], sda_sync};
        last_bit    = (bit_cnt_q == '1);
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = load_q ? reg_rdata : tx_q;
        rw_d        = rw_q;
        sda_o_d     = sda_o_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        load_d      = reg_re_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_o_d   = SDA_RELEASE;
        end else if (stop_det) begin
            state_d = IDLE;
            sda_o_d = SDA_RELEASE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            case (state_q)
                                ADDR: begin
                                    if (rx_byte[7:1] == TARGET_ADDR) begin
                                        busy_d   = 1'b1;
                                        rw_d     = rx_byte[0];
                                        reg_re_d = rx_byte[0];
                                        state_d  = ADDR_ACK;
                                    end else begin
                                        busy_d  = 1'b0;
                                        state_d = WAIT_STOP;
                                    end
                                end
                                PTR: begin
                                    reg_addr_d = REG_ADDR_WIDTH'(rx_byte);
                                    state_d    = PTR_ACK;
                                end
                                default: begin
                                    reg_wdata_d = rx_byte;
                                    reg_we_d    = 1'b1;
                                    state_d     = WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                // bit_cnt doubles as the ACK phase: 0 = awaiting first fall, 1 = driving ACK.
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == '0) begin
                            sda_o_d   = SDA_LOW;
                            bit_cnt_d = BIT_CNT_W'(1);
                        end else begin
                            bit_cnt_d = '0;
                            sda_o_d   = SDA_RELEASE;
                            if (state_q == ADDR_ACK && rw_q) begin
                                sda_o_d = tx_q[7];
                                tx_d    = {tx_q[6:0], 1'b0};
                                state_d = RD;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                if (state_q == WR_ACK) begin
                                    reg_addr_d = reg_addr_q + 1'b1;
                                end
                                state_d = WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (last_bit) begin
                            sda_o_d   = SDA_RELEASE;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            sda_o_d   = tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync) begin
                            reg_addr_d = reg_addr_q + 1'b1;
                            reg_re_d   = 1'b1;
                        end else begin
                            sda_o_d = SDA_RELEASE;
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        sda_o_d   = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = '0;
                        state_d   = RD;
                    end
                end
                default: begin
                    sda_o_d = SDA_RELEASE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            sda_o_q     <= SDA_RELEASE;
            busy_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            sda_o_q     <= sda_o_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            load_q      <= load_d;
        end
    end

    assign ext_sda_o = sda_o_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level host driving directed and random transfers,
// checked against a register-file model of what the host intends.
module tb_i2c_target;

    localparam int unsigned Q = 50;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       scl   = 1'b1;
    logic       sda_h = 1'b1;
    logic       mem_load = 1'b1;
    logic       sda_line;
    logic       ext_sda_o;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    assign sda_line = sda_h & ext_sda_o;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h50), .REG_ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ext_scl_i (scl),
        .ext_sda_i (sda_line),
        .ext_sda_o (ext_sda_o),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    logic [7:0]  dut_mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [7:0]  re_addr_q [$];
    logic [7:0]  tx_bytes  [$];
    int unsigned sda_low_cnt = 0;
    int unsigned busy_cnt    = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic logic [7:0] init_val(input int unsigned a);
        if (a == 32'h20) return 8'hC3;
        if (a == 32'h21) return 8'h7E;
        return 8'((a * 37 + 91) & 255);
    endfunction

    // Register file on the local bus; also logs every strobe it sees.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) dut_mem[i] <= init_val(i);
        end else begin
            if (reg_we) begin
                dut_mem[reg_addr] <= reg_wdata;
                wr_addr_q.push_back(reg_addr);
                wr_data_q.push_back(reg_wdata);
            end
            if (reg_re) begin
                reg_rdata <= dut_mem[reg_addr];
                re_addr_q.push_back(reg_addr);
            end
            if (!ext_sda_o) sda_low_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_h = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_h = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_h = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_h = 1'b1; #Q;
        #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_h = b; #Q;
        scl   = 1'b1; #(2 * Q);
        scl   = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_h = 1'b1; #Q;
        scl   = 1'b1; #Q;
        b     = sda_line; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    // Write tx_bytes starting at ptr; expect each byte at ptr+i modulo 256.
    task automatic do_write(input logic [7:0] ptr, input string tag);
        logic        ack;
        int unsigned base;
        base = wr_addr_q.size();
        bus_start();
        wr_byte(8'hA0, ack); chk({tag, " addr_ack"}, ack, 1);
        wr_byte(ptr, ack);   chk({tag, " ptr_ack"}, ack, 1);
        foreach (tx_bytes[i]) begin
            wr_byte(tx_bytes[i], ack);
            chk({tag, " data_ack"}, ack, 1);
        end
        chk({tag, " busy_mid"}, busy, 1);
        bus_stop();
        chk({tag, " busy_after_stop"}, busy, 0);
        chk({tag, " we_count"}, wr_addr_q.size() - base, tx_bytes.size());
        foreach (tx_bytes[i]) begin
            if (base + i < wr_addr_q.size()) begin
                chk({tag, " we_addr"}, wr_addr_q[base + i], 8'(ptr + i));
                chk({tag, " we_data"}, wr_data_q[base + i], tx_bytes[i]);
            end
            ref_mem[8'(ptr + i)] = tx_bytes[i];
        end
    endtask

    // Random read of n bytes from ptr; host ACKs all but the last.
    task automatic do_read(input logic [7:0] ptr, input int unsigned n, input string tag);
        logic        ack;
        logic [7:0]  d;
        int unsigned rbase, wbase;
        rbase = re_addr_q.size();
        wbase = wr_addr_q.size();
        bus_start();
        wr_byte(8'hA0, ack); chk({tag, " addr_ack"}, ack, 1);
        wr_byte(ptr, ack);   chk({tag, " ptr_ack"}, ack, 1);
        bus_start();
        wr_byte(8'hA1, ack); chk({tag, " raddr_ack"}, ack, 1);
        for (int unsigned i = 0; i < n; i++) begin
            rd_byte(d, i != n - 1);
            chk({tag, " rdata"}, d, ref_mem[8'(ptr + i)]);
        end
        chk({tag, " busy_after_nack"}, busy, 0);
        bus_stop();
        chk({tag, " re_count"}, re_addr_q.size() - rbase, n);
        for (int unsigned i = 0; i < n; i++) begin
            if (rbase + i < re_addr_q.size())
                chk({tag, " re_addr"}, re_addr_q[rbase + i], 8'(ptr + i));
        end
        chk({tag, " no_we"}, wr_addr_q.size() - wbase, 0);
    endtask

    initial begin
        logic        ack;
        logic [7:0]  p;
        int unsigned n, lowb, busyb, wb;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        chk("rst sda_o", ext_sda_o, 1);
        chk("rst we", reg_we, 0);
        chk("rst re", reg_re, 0);
        chk("rst busy", busy, 0);
        chk("rst addr", reg_addr, 0);
        chk("rst wdata", reg_wdata, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        tx_bytes = '{8'h5A, 8'h3C};
        do_write(8'h10, "wr_stop");

        do_read(8'h20, 2, "rand_read");
        chk("rand_read mem20", ref_mem[8'h20], 8'hC3);

        lowb  = sda_low_cnt;
        busyb = busy_cnt;
        wb    = wr_addr_q.size();
        bus_start();
        wr_byte(8'hA2, ack); chk("wrong_addr ack0", ack, 0);
        wr_byte(8'h10, ack); chk("wrong_addr ack1", ack, 0);
        wr_byte(8'h55, ack); chk("wrong_addr ack2", ack, 0);
        bus_stop();
        chk("wrong_addr sda_low", sda_low_cnt - lowb, 0);
        chk("wrong_addr busy", busy_cnt - busyb, 0);
        chk("wrong_addr no_we", wr_addr_q.size() - wb, 0);

        bus_start();
        wr_byte(8'h00, ack); chk("gen_call ack", ack, 0);
        bus_stop();

        tx_bytes = '{8'h01, 8'h02};
        do_write(8'hFF, "ptr_wrap");

        wb = wr_addr_q.size();
        bus_start();
        wr_byte(8'hA0, ack); chk("abort addr_ack", ack, 1);
        wr_byte(8'h30, ack); chk("abort ptr_ack", ack, 1);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop();
        chk("abort no_we", wr_addr_q.size() - wb, 0);
        chk("abort busy", busy, 0);
        tx_bytes = '{8'h77};
        do_write(8'h31, "after_abort");

        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            tx_bytes.delete();
            for (int unsigned k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
            do_write(p, "rnd_wr");
            do_read(8'(p + $urandom_range(0, n - 1)), $urandom_range(1, 3), "rnd_rd");
        end
        do_read(8'($urandom_range(0, 255)), 2, "rnd_rd_any");

        tx_bytes = '{8'h12};
        do_write(8'h40, "pre_reset");
        bus_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h40, ack);
        bus_start();
        wr_byte(8'hA1, ack); chk("midrd addr_ack", ack, 1);
        chk("midrd drive0", ext_sda_o, 0);
        reset = 1'b0;
        #1;
        chk("midrd rst sda_o", ext_sda_o, 1);
        chk("midrd rst we", reg_we, 0);
        chk("midrd rst re", reg_re, 0);
        chk("midrd rst busy", busy, 0);
        chk("midrd rst addr", reg_addr, 0);
        chk("midrd rst wdata", reg_wdata, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus_stop();
        tx_bytes = '{8'h9D};
        do_write(8'h50, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
